input_debouncer: RTL and testbench

//   Synchronises and debounces WIDTH raw asynchronous inputs (switches/buttons)
//   and presents clean, glitch-free levels to downstream combinational gates.

---
 rtl/input_debouncer.sv | 71 +++++++
 tb/tb_input_debouncer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchroniser plus per-bit stable-count filter; define DEBOUNCE_EDGE_EN to add rise/fall pulses
module input_debouncer #(
   parameter int WIDTH         = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] busy
`ifdef DEBOUNCE_EDGE_EN
   ,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
`endif
);
   typedef enum logic {STABLE, PENDING} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   logic [WIDTH-1:0] sync1, sync2, dout_nx;
   state_t           state [WIDTH];
   state_t           state_nx [WIDTH];
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [CNT_W-1:0] cnt_nx [WIDTH];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         dout  <= '0;
         for (int b = 0; b < WIDTH; b++) begin
            state[b] <= STABLE;
            cnt[b]   <= '0;
         end
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         dout  <= dout_nx;
         for (int b = 0; b < WIDTH; b++) begin
            state[b] <= state_nx[b];
            cnt[b]   <= cnt_nx[b];
         end
      end
   // any sample equal to dout drops the candidate; cnt only runs while PENDING
   always_comb
      for (int b = 0; b < WIDTH; b++) begin
         state_nx[b] = STABLE;
         cnt_nx[b]   = '0;
         dout_nx[b]  = dout[b];
         if (sync2[b] != dout[b]) begin
            if (STABLE_CYCLES == 1 || (state[b] == PENDING && cnt[b] == LAST)) begin
               dout_nx[b] = sync2[b];
            end else begin
               state_nx[b] = PENDING;
               cnt_nx[b]   = (state[b] == PENDING) ? cnt[b] + 1'b1 : CNT_W'(1);
            end
         end
      end
   always_comb
      for (int b = 0; b < WIDTH; b++)
         busy[b] = (state[b] == PENDING);
`ifdef DEBOUNCE_EDGE_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rise <= '0;
         fall <= '0;
      end else begin
         rise <= dout_nx & ~dout;
         fall <= ~dout_nx & dout;
      end
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: randomized scoreboard bench against a sliding-window debounce model
module tb_input_debouncer;
   localparam int W = 2;
   localparam int N = 4;
   typedef logic [4*W-1:0] vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout, busy;
`ifdef DEBOUNCE_EDGE_EN
   logic [W-1:0] rise, fall;
`endif

   always #5 clk = ~clk;

   input_debouncer #(.WIDTH(W), .STABLE_CYCLES(N), .CNT_W(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .din(din),
      .dout(dout),
      .busy(busy)
`ifdef DEBOUNCE_EDGE_EN
      ,
      .rise(rise),
      .fall(fall)
`endif
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   vec_t exp_q[$];

   // model: the last N synchronised samples; dout flips when all of them disagree with it
   logic [W-1:0] m_s1 = '0, m_s2 = '0, m_dout = '0;
   logic [W-1:0] hist [N];

   task automatic model_reset();
      m_s1 = '0;
      m_s2 = '0;
      m_dout = '0;
      for (int j = 0; j < N; j++) hist[j] = '0;
   endtask

   task automatic step(input logic [W-1:0] d);
      logic [W-1:0] smp, nd, nb, rs, fl;
      logic all_diff;
      din = d;
      smp = m_s2;
      for (int j = N - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = smp;
      for (int b = 0; b < W; b++) begin
         all_diff = 1'b1;
         for (int j = 0; j < N; j++) all_diff &= (hist[j][b] != m_dout[b]);
         nd[b] = all_diff ? smp[b] : m_dout[b];
      end
      nb = smp ^ nd;
      rs = nd & ~m_dout;
      fl = ~nd & m_dout;
      m_s2 = m_s1;
      m_s1 = d;
      m_dout = nd;
`ifdef DEBOUNCE_EDGE_EN
      exp_q.push_back({nd, nb, rs, fl});
`else
      exp_q.push_back({nd, nb, {2*W{1'b0}}});
`endif
      @(negedge clk);
   endtask

   task automatic run(input logic [W-1:0] d, input int n);
      repeat (n) step(d);
   endtask

   task automatic hold_reset(input logic [W-1:0] d, input int n);
      din = d;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({dout, busy} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: dout=%b busy=%b, need 00 00", dout, busy);
      end
      model_reset();
      repeat (n) begin
         exp_q.push_back('0);
         @(negedge clk);
      end
      rst_n = 1'b1;
   endtask

   initial forever begin
      vec_t e, a;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
`ifdef DEBOUNCE_EDGE_EN
         a = {dout, busy, rise, fall};
`else
         a = {dout, busy, {2*W{1'b0}}};
`endif
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL outputs cyc %0d: dout/busy/rise/fall got %b, need %b", cyc, a, e);
         end
      end
   end

   initial begin
      int waited;
      model_reset();
      din = 2'b11;
      @(negedge clk);
      hold_reset(2'b11, 3);
      run(2'b00, 4);
      run(2'b01, 10);
      run(2'b10, 3);
      run(2'b00, 8);
      run(2'b10, 4);
      run(2'b00, 8);
      run(2'b11, 8);
      run(2'b00, 8);
      run(2'b01, 4);
      hold_reset(2'b01, 2);
      run(2'b01, 10);
      run(2'b00, 8);
      repeat (300) begin
         if ($urandom_range(0, 39) == 0)
            hold_reset(W'($urandom), $urandom_range(1, 3));
         else
            run(W'($urandom), $urandom_range(1, 6));
      end
      run(2'b00, N + 4);
      waited = 0;
      while (exp_q.size() != 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
